// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  // Comparator control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_e;

  // Result encoding, packed as {gt, eq, lt}.
  localparam int unsigned CMP_RES_W = 3;
  localparam logic [CMP_RES_W-1:0] CMP_GT = 3'b100;
  localparam logic [CMP_RES_W-1:0] CMP_EQ = 3'b010;
  localparam logic [CMP_RES_W-1:0] CMP_LT = 3'b001;

endpackage

// File: rtl/comparator_2b.sv
// 1-bit equality cell: compares two single bits, combinational result.
module comparator_2b (
  input  logic a_i,
  input  logic b_i,
  output logic eq_c_o
);

  // High when both bits agree.
  assign eq_c_o = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with start/busy/done.
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to finish on the cycle after
// the first mismatching bit instead of always walking all W bits.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  localparam int unsigned CNT_W = $clog2(W) + 1;

  cmp_state_e           state_q, state_d;
  logic [W-1:0]         sa_q, sa_d;
  logic [W-1:0]         sb_q, sb_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 decided_q, decided_d;
  logic                 gt_r_q, gt_r_d;
  logic                 lt_r_q, lt_r_d;
  logic [CMP_RES_W-1:0] res_q, res_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 msb_eq_c;
  logic                 first_miss_c;
  logic                 last_bit_c;

  comparator_2b u_msb_cmp (
    .a_i    (sa_q[W-1]),
    .b_i    (sb_q[W-1]),
    .eq_c_o (msb_eq_c)
  );

  // First differing bit not yet recorded.
  assign first_miss_c = ~msb_eq_c & ~decided_q;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last_bit_c = (cnt_q == CNT_W'(1)) | first_miss_c;
`else
  assign last_bit_c = (cnt_q == CNT_W'(1));
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_r_d    = gt_r_q;
    lt_r_d    = lt_r_q;
    res_d     = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sa_d      = a;
          sb_d      = b;
          cnt_d     = CNT_W'(W);
          decided_d = 1'b0;
          gt_r_d    = 1'b0;
          lt_r_d    = 1'b0;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (first_miss_c) begin
          gt_r_d    = sa_q[W-1];
          lt_r_d    = sb_q[W-1];
          decided_d = 1'b1;
        end
        sa_d  = sa_q << 1;
        sb_d  = sb_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (last_bit_c) begin
          state_d = DONE;
          res_d   = !decided_d ? CMP_EQ : (gt_r_d ? CMP_GT : CMP_LT);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_r_q    <= 1'b0;
      lt_r_q    <= 1'b0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_r_q    <= gt_r_d;
      lt_r_q    <= lt_r_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = res_q[2];
  assign eq   = res_q[1];
  assign lt   = res_q[0];

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Multi-cycle, bit-serial magnitude comparator built around the team's 1-bit equality cell.
- Captures two W-bit operands on a start handshake and walks them MSB-first, one bit per clock.
- Reports eq/gt/lt with a done pulse.
- Sits downstream of operand registers and upstream of control logic that needs ordered compares, such as sort or threshold units, where area matters more than latency.

Parameters:
- W, 8, operand width in bits; legal range W >= 1.
- CNT_W, $clog2(W)+1, internal bit-counter width (derived; not overridden by users).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to compare; sampled only when busy=0.
- a  input  W  operand A; unsigned; sampled on the accepting edge only.
- b  input  W  operand B; unsigned; sampled on the accepting edge only.
- busy  output  1  high while a comparison is in progress.
- done  output  1  single-cycle pulse; results valid from this cycle onward.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.

Behaviour:
- Reset (sync, active-high): state=IDLE; busy=0, done=0, eq=0, gt=0, lt=0; shift registers and counter cleared. Reset asserted mid-SHIFT aborts the comparison, with no done pulse.
- States:
  - IDLE: start=1 -> load a, b into shift regs sa, sb; cnt=W; decided=0; go SHIFT. busy rises on the next cycle.
  - SHIFT: busy=1. Each cycle, the equality cell compares sa[W-1] and sb[W-1].
    - If not equal and decided=0: latch gt_r=sa[W-1], lt_r=sb[W-1], set decided=1.
    - Shift sa and sb left by 1; cnt decrements.
    - When cnt reaches 1 this cycle: go DONE.
  - DONE: for one cycle, done=1, busy=0.
    - Outputs: eq=~decided, gt=gt_r, lt=lt_r.
    - start=1 in this cycle is accepted (same as in IDLE) -> SHIFT; otherwise -> IDLE.
- Result outputs are registered and hold their values until the next done pulse. They are not cleared when a new start is accepted.
- After the first completion, exactly one of eq/gt/lt is high.
- Latency (default build): start edge -> done high exactly W+1 cycles later, independent of data.
- start while busy=1 is ignored. a and b may change freely after the accepting edge.
- Operands are unsigned; no signed interpretation.
- W=1: one SHIFT cycle, then DONE.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined: SHIFT goes to DONE on the cycle after the first mismatching bit is seen. Latency = k+1 cycles, where k = 1-based position of the first mismatch from the MSB. Equal operands still take W+1 cycles.
- Undefined: fixed W+1 latency. The decided flag alone masks later bits.
- Results are identical in both builds; only timing differs.

Decomposition:
- Shared package serial_cmp_pkg holds:
  - state enum: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2;
  - result-encoding constants CMP_EQ, CMP_GT, CMP_LT, used by consumers that pack {gt,eq,lt}.
- One sub-module: the existing 1-bit equality cell comparator_2b, instantiated once on the operand MSBs. Its output drives the mismatch detection.
- The FSM, counter and shift registers stay in serial_mag_comparator.

Test Plan:
- Reset then idle: hold reset 2 cycles, start=0 -> busy=done=eq=gt=lt=0 for 10 cycles.
- W=8, a=8'hA5, b=8'hA5, start 1 cycle -> busy for 8 cycles, done pulse at cycle 9, eq=1 gt=0 lt=0.
- a=8'h80, b=8'h7F -> gt=1 eq=0 lt=0. Done at cycle 9 in the default build; at cycle 2 with SERIAL_CMP_EARLY_EXIT_EN.
- a=8'h12, b=8'h13 -> lt=1. Done at cycle 9 in both builds (mismatch is at the LSB).
- Pulse start=1 with new a/b at cycle 4 while busy -> ignored; the result matches the first operands. Start held high during the DONE cycle with a=3, b=9 -> back-to-back compare, lt=1 nine cycles later.
- Assert reset at cycle 5 of a compare -> no done pulse, all outputs 0. The next start/compare completes normally.
